// File: rtl/iqueue.sv
// Instruction queue between fetch and decode: a circular FIFO of DEPTH entries
// with show-ahead output. When the queue is empty, the output presents a NOP.
package iqueue_pkg;
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instruction;
        logic        prediction;
        logic [15:0] prediction_pc;
    } lc3b_iqueue_entry;
endpackage

module iqueue
    import iqueue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       push,
    input  lc3b_iqueue_entry           data_in,
    output logic                       full,
    input  logic                       pop,
    output lc3b_iqueue_entry           data_out,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    lc3b_iqueue_entry slots [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    // An empty queue presents BR-never (all zeros) so that decode keeps flowing.
    assign data_out = empty ? '0 : slots[head];

    // NOTE: all sequential state uses non-blocking assignments, so every
    // always_ff reads the pre-edge values of the signals it depends on.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // The pointers wrap naturally because DEPTH is a power of two.
            if (push_ok) tail <= tail + PW'(1);
            if (pop_ok)  head <= head + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is intentionally left without a reset; validity comes only
    // from the pointers and the count, which keeps the array a plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) slots[tail] <= data_in;
    end
endmodule

// File: tb/tb_iqueue.sv
// Self-checking bench for iqueue: directed table, corner sequences and random
// traffic, all compared against a queue-based reference model.
module tb_iqueue;
    import iqueue_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 flush = 1'b0;
    logic                 push = 1'b0;
    logic                 pop = 1'b0;
    lc3b_iqueue_entry     data_in = '0;
    lc3b_iqueue_entry     data_out;
    logic                 full;
    logic                 empty;
    logic [CW-1:0]        count;

    int checks = 0;
    int errors = 0;

    lc3b_iqueue_entry model_q [$];

    iqueue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .push     (push),
        .data_in  (data_in),
        .full     (full),
        .pop      (pop),
        .data_out (data_out),
        .empty    (empty),
        .count    (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        fl;
        logic        pu;
        logic        po;
        logic [15:0] pc;
        int          exp_count;
        logic        exp_empty;
        logic        exp_full;
        logic [15:0] exp_pc;
    } vec_t;

    function automatic lc3b_iqueue_entry mk(input logic [15:0] pc);
        lc3b_iqueue_entry e;
        e.pc            = pc;
        e.instruction   = pc ^ 16'h1234;
        e.prediction    = pc[1];
        e.prediction_pc = pc + 16'd2;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one cycle, advances the reference model and compares all outputs.
    task automatic step(input logic r, input logic f, input logic pu, input logic po,
                        input lc3b_iqueue_entry d);
        bit take_push;
        bit take_pop;
        lc3b_iqueue_entry exp_out;
        @(negedge clk);
        reset_n = r; flush = f; push = pu; pop = po; data_in = d;
        @(posedge clk);
        if (!r || f) begin
            model_q.delete();
        end else begin
            take_push = pu && (model_q.size() < DEPTH);
            take_pop  = po && (model_q.size() > 0);
            if (take_pop)  void'(model_q.pop_front());
            if (take_push) model_q.push_back(d);
        end
        #1;
        exp_out = (model_q.size() == 0) ? '0 : model_q[0];
        check("count",    64'(count),    64'(model_q.size()));
        check("empty",    64'(empty),    64'(model_q.size() == 0));
        check("full",     64'(full),     64'(model_q.size() == DEPTH));
        check("data_out", 64'(data_out), 64'(exp_out));
    endtask

    vec_t vecs [12];

    initial begin
        lc3b_iqueue_entry e;
        bit seen_4000;

        // rst_n fl pu po pc | count empty full pc
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h3000, 1, 1'b0, 1'b0, 16'h3000};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h3002, 2, 1'b0, 1'b0, 16'h3000};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1, 1'b0, 1'b0, 16'h3002};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h3004, 1, 1'b0, 1'b0, 16'h3004};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 0, 1'b1, 1'b0, 16'h0000};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 0, 1'b1, 1'b0, 16'h0000};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h3006, 0, 1'b1, 1'b0, 16'h0000};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h3008, 1, 1'b0, 1'b0, 16'h3008};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h300A, 0, 1'b1, 1'b0, 16'h0000};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h300C, 1, 1'b0, 1'b0, 16'h300C};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 16'h0000};

        step(1'b0, 1'b0, 1'b0, 1'b0, '0);

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rst_n, vecs[i].fl, vecs[i].pu, vecs[i].po, mk(vecs[i].pc));
            check("tbl_count", 64'(count), 64'(vecs[i].exp_count));
            check("tbl_empty", 64'(empty), 64'(vecs[i].exp_empty));
            check("tbl_full",  64'(full),  64'(vecs[i].exp_full));
            check("tbl_data",  64'(data_out),
                  vecs[i].exp_empty ? 64'd0 : 64'(mk(vecs[i].exp_pc)));
        end

        // Fill and drain from reset.
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) begin
            e = mk(16'(2 * i));
            e.instruction = 16'h1000 + 16'(i);
            step(1'b1, 1'b0, 1'b1, 1'b0, e);
        end
        check("fill_full",  64'(full),  64'd1);
        check("fill_count", 64'(count), 64'd8);
        step(1'b1, 1'b0, 1'b1, 1'b0, mk(16'h0100));
        check("drop_count", 64'(count), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check("drain_pc", 64'(data_out.pc), 64'(2 * i));
            step(1'b1, 1'b0, 1'b0, 1'b1, '0);
        end
        check("drain_empty", 64'(empty), 64'd1);
        check("drain_nop",   64'(data_out.instruction), 64'h0000);

        // Wrap-around at constant occupancy of 3.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, mk(16'h2000 + 16'(i)));
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1, mk(16'h2100 + 16'(i)));
            check("wrap_count", 64'(count), 64'd3);
        end

        // Flush during push with 5 entries held.
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b1, 1'b0, mk(16'h2200 + 16'(i)));
        check("pre_flush_count", 64'(count), 64'd5);
        step(1'b1, 1'b1, 1'b1, 1'b0, mk(16'h4000));
        check("flush_count", 64'(count), 64'd0);
        seen_4000 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, '0);
            if (data_out.pc == 16'h4000) seen_4000 = 1'b1;
        end
        check("flush_no_4000", 64'(seen_4000), 64'd0);

        // Full with push and pop together.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 1'b0, mk(16'h5100 + 16'(i)));
        step(1'b1, 1'b0, 1'b1, 1'b1, mk(16'h5000));
        check("full_pp_count", 64'(count), 64'd7);
        check("full_pp_head",  64'(data_out.pc), 64'h5101);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b1, '0);

        // Reset mid-operation, then push right after.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, mk(16'h6100 + 16'(i)));
        step(1'b0, 1'b0, 1'b1, 1'b0, mk(16'h6200));
        check("rst_count", 64'(count), 64'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, mk(16'h6000));
        check("rst_push_pc", 64'(data_out.pc), 64'h6000);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 50),
                 lc3b_iqueue_entry'({$urandom, $urandom}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
